// File: rtl/inst_fetch_pkg.sv
// Shared opcode constants, fetch-queue entry type and immediate decoders for
// the fetch stage.
package inst_fetch_pkg;

    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [31:0] FE_BUBBLE     = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fq_entry_t;

    function automatic logic [31:0] b_imm(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] ir);
        return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_fe_queue.sv
// Small circular FIFO of {pc, ir} entries between the instruction memory
// response port and the fetch/decode pipeline register.
module fe_queue
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fq_entry_t                    push_data_i,
    input  logic                         pop_i,
    output fq_entry_t                    head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t     mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the fetch PC, issues word requests to instruction memory,
// buffers responses and drives the fe2de pipeline register with static prediction.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_stall,
    input  logic        branch_predict_err,
    input  logic [31:0] de2fe_branch_target,
    input  logic        ex2fe_redirect,
    input  logic [31:0] ex2fe_redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] fe2de_pc_ffout,
    output logic [31:0] fe2de_ir_ffout,
    output logic        fe2de_predict_bxxtaken_ffout,
    output logic        fe2de_rv16_ffout
);

    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic          run_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   fe_pc_q, fe_pc_d;
    logic [31:0]   fe_ir_q, fe_ir_d;
    logic          fe_pred_q, fe_pred_d;

    fq_entry_t     head, push_entry;
    logic          q_full, q_empty;
    logic [CW-1:0] q_count;
    logic [CW:0]   slots_used;

    logic          bpe_acc, kill, pop, is_bxx, is_jal, pred_hit, redirect;
    logic          gnt_fire, rsp_drop, push;
    logic [31:0]   redirect_pc;

    assign is_bxx  = (head.ir[6:0] == OPCODE_BRANCH) & head.ir[31];
    assign is_jal  = (head.ir[6:0] == OPCODE_JAL);

    assign bpe_acc  = branch_predict_err & ~de_stall & ~ex2fe_redirect;
    assign kill     = ex2fe_redirect | bpe_acc;
    assign pop      = ~de_stall & ~q_empty & ~kill;
    assign pred_hit = pop & (is_bxx | is_jal);
    assign redirect = kill | pred_hit;

    always_comb begin
        if (ex2fe_redirect)   redirect_pc = ex2fe_redirect_pc;
        else if (bpe_acc)     redirect_pc = de2fe_branch_target;
        else if (is_jal)      redirect_pc = head.pc + j_imm(head.ir);
        else                  redirect_pc = head.pc + b_imm(head.ir);
    end

    // Occupancy counts the slot freed by this cycle's pop so the queue can stream at 1/cycle.
    assign slots_used = {1'b0, q_count} - (CW+1)'(pop) + {1'b0, outst_q};
    assign imem_req   = run_q & (slots_used < (CW+1)'(FQ_DEPTH));
    assign imem_addr  = fetch_pc_q;

    assign gnt_fire   = imem_req & imem_gnt;
    assign rsp_drop   = imem_rvalid & (discard_q != '0);
    assign push       = imem_rvalid & ~rsp_drop & ~redirect & (~q_full | pop);
    assign push_entry = '{pc: rsp_pc_q, ir: imem_rdata};

    fe_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    // After a redirect every response still in flight belongs to the wrong path.
    always_comb begin
        outst_d = outst_q + CW'(gnt_fire) - CW'(imem_rvalid);
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = redirect_pc;
            discard_d  = outst_d;
        end else begin
            fetch_pc_d = gnt_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
            rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
            discard_d  = rsp_drop ? discard_q - CW'(1) : discard_q;
        end
    end

    always_comb begin
        fe_pc_d   = fe_pc_q;
        fe_ir_d   = fe_ir_q;
        fe_pred_d = fe_pred_q;
        if (kill) begin
            fe_ir_d   = FE_BUBBLE;
            fe_pred_d = 1'b0;
        end else if (!de_stall) begin
            if (!q_empty) begin
                fe_pc_d   = head.pc;
                fe_ir_d   = head.ir;
                fe_pred_d = is_bxx;
            end else begin
                fe_ir_d   = FE_BUBBLE;
                fe_pred_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            fe_pc_q    <= RESET_PC;
            fe_ir_q    <= FE_BUBBLE;
            fe_pred_q  <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            fe_pc_q    <= fe_pc_d;
            fe_ir_q    <= fe_ir_d;
            fe_pred_q  <= fe_pred_d;
        end
    end

    assign fe2de_pc_ffout               = fe_pc_q;
    assign fe2de_ir_ffout               = fe_ir_q;
    assign fe2de_predict_bxxtaken_ffout = fe_pred_q;
    assign fe2de_rv16_ffout             = 1'b0;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: in-order random-latency memory, scripted then random
// decode/execute redirects, and a program-level model of the expected stream.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 2;
    localparam int          N_CYC    = 1600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de_stall = 1'b0;
    logic        branch_predict_err = 1'b0;
    logic [31:0] de2fe_branch_target = '0;
    logic        ex2fe_redirect = 1'b0;
    logic [31:0] ex2fe_redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] fe2de_pc_ffout;
    logic [31:0] fe2de_ir_ffout;
    logic        fe2de_predict_bxxtaken_ffout;
    logic        fe2de_rv16_ffout;

    inst_fetch #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .de_stall                     (de_stall),
        .branch_predict_err           (branch_predict_err),
        .de2fe_branch_target          (de2fe_branch_target),
        .ex2fe_redirect               (ex2fe_redirect),
        .ex2fe_redirect_pc            (ex2fe_redirect_pc),
        .imem_req                     (imem_req),
        .imem_addr                    (imem_addr),
        .imem_gnt                     (imem_gnt),
        .imem_rvalid                  (imem_rvalid),
        .imem_rdata                   (imem_rdata),
        .fe2de_pc_ffout               (fe2de_pc_ffout),
        .fe2de_ir_ffout               (fe2de_ir_ffout),
        .fe2de_predict_bxxtaken_ffout (fe2de_predict_bxxtaken_ffout),
        .fe2de_rv16_ffout             (fe2de_rv16_ffout)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Program image: a few hand-placed control-flow words, everything else addr|0x13.
    // 0x20 BEQ -16 -> 0x10, 0x40 BNE +8 (forward), 0x120 JAL +0x40, 0x208 BNE -8 -> 0x200.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0020: return 32'hFE00_08E3;
            32'h0000_0040: return 32'h0000_1463;
            32'h0000_0120: return 32'h0400_006F;
            32'h0000_0208: return 32'hFE00_1CE3;
            default:       return a | 32'h13;
        endcase
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] a);
        case (a)
            32'h0000_0020: return 32'h0000_0010;
            32'h0000_0120: return 32'h0000_0160;
            32'h0000_0208: return 32'h0000_0200;
            default:       return a + 32'd4;
        endcase
    endfunction

    function automatic logic is_taken_bxx(input logic [31:0] a);
        return (a == 32'h20) || (a == 32'h208);
    endfunction

    function automatic logic is_pred_redirect(input logic [31:0] a);
        return (a == 32'h20) || (a == 32'h120) || (a == 32'h208);
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0010;
            1: return 32'h0000_0100;
            2: return 32'h0000_01FC;
            3: return 32'hFFFF_FFF8;
            4: return 32'h0000_0200;
            default: return 32'($urandom_range(0, 255)) * 32'd4;
        endcase
    endfunction

    logic [31:0] rq_addr[$];
    int          rq_rdy[$];
    int          last_rdy = -1;

    logic        p_load = 1'b1, p_kill = 1'b0, p_req = 1'b0, p_gnt = 1'b0;
    logic [31:0] p_addr = '0, p_target = '0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] last_pc = RESET_PC, last_ir = '0;
    logic        last_pred = 1'b0;
    logic        pred_redir, lat_pend = 1'b0;
    int          red_cyc = 0, n_loads = 0;
    logic        stall, bpe, ex, gnt;
    logic [31:0] bpe_t, ex_t;
    int          lat, rdy;

    initial begin
        #3;
        chk("rst_req",  32'(imem_req), 32'd0);
        chk("rst_pc",   fe2de_pc_ffout, RESET_PC);
        chk("rst_ir",   fe2de_ir_ffout, 32'd0);
        chk("rst_pred", 32'(fe2de_predict_bxxtaken_ffout), 32'd0);
        chk("rst_rv16", 32'(fe2de_rv16_ffout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            pred_redir = 1'b0;
            if (p_kill) begin
                chk("kill_bubble", fe2de_ir_ffout, 32'd0);
                chk("kill_addr", imem_addr, p_target);
                exp_pc   = p_target;
                red_cyc  = cyc - 1;
                lat_pend = (cyc < 95);
            end else if (!p_load) begin
                chk("hold_pc", fe2de_pc_ffout, last_pc);
                chk("hold_ir", fe2de_ir_ffout, last_ir);
                chk("hold_pred", 32'(fe2de_predict_bxxtaken_ffout), 32'(last_pred));
            end else if (fe2de_ir_ffout != 32'd0) begin
                chk("pc", fe2de_pc_ffout, exp_pc);
                chk("ir", fe2de_ir_ffout, mem_word(exp_pc));
                chk("pred", 32'(fe2de_predict_bxxtaken_ffout), 32'(is_taken_bxx(exp_pc)));
                if (lat_pend) begin
                    chk("redir_latency", 32'(cyc - red_cyc), 32'd4);
                    lat_pend = 1'b0;
                end
                if (is_pred_redirect(exp_pc)) begin
                    chk("pred_addr", imem_addr, next_pc(exp_pc));
                    pred_redir = 1'b1;
                end
                exp_pc = next_pc(exp_pc);
                n_loads++;
            end else begin
                chk("bubble_pc", fe2de_pc_ffout, last_pc);
                chk("bubble_pred", 32'(fe2de_predict_bxxtaken_ffout), 32'd0);
            end
            if (cyc >= 3 && cyc <= 11) begin
                chk("seq_pc", fe2de_pc_ffout, 32'((cyc - 3) * 4));
                chk("seq_nobubble", 32'(fe2de_ir_ffout != 32'd0), 32'd1);
            end
            last_pc   = fe2de_pc_ffout;
            last_ir   = fe2de_ir_ffout;
            last_pred = fe2de_predict_bxxtaken_ffout;

            stall = 1'b0; bpe = 1'b0; ex = 1'b0; gnt = 1'b1; lat = 1;
            bpe_t = $urandom; ex_t = $urandom;
            if (cyc < 100) begin
                case (cyc)
                    30:         begin bpe = 1'b1; bpe_t = 32'h100; end
                    40, 41, 42: stall = 1'b1;
                    50:         begin ex = 1'b1; ex_t = 32'h200; bpe = 1'b1; bpe_t = 32'h100; end
                    60:         begin bpe = 1'b1; bpe_t = 32'h300; stall = 1'b1; end
                    70, 71, 72, 73, 74: gnt = 1'b0;
                    80:         begin ex = 1'b1; ex_t = 32'hFFFF_FFF0; end
                    default:    ;
                endcase
            end else begin
                gnt   = ($urandom_range(0, 3) != 0);
                lat   = $urandom_range(1, 3);
                stall = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 39) == 0) begin ex = 1'b1; ex_t = pick_target(); end
                if ($urandom_range(0, 29) == 0) begin bpe = 1'b1; bpe_t = pick_target(); end
            end
            de_stall            = stall;
            branch_predict_err  = bpe;
            de2fe_branch_target = bpe_t;
            ex2fe_redirect      = ex;
            ex2fe_redirect_pc   = ex_t;
            imem_gnt            = gnt;
            if (rq_addr.size() > 0 && rq_rdy[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(rq_addr.pop_front());
                void'(rq_rdy.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end

            #1;
            if (p_req && !p_gnt && !p_kill && !pred_redir) begin
                chk("req_hold", 32'(imem_req), 32'd1);
                chk("addr_hold", imem_addr, p_addr);
            end
            if (cyc == 42) chk("stall_req_drop", 32'(imem_req), 32'd0);
            if (imem_req && imem_gnt) begin
                chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
                rdy = cyc + lat;
                if (rdy <= last_rdy) rdy = last_rdy + 1;
                last_rdy = rdy;
                rq_addr.push_back(imem_addr);
                rq_rdy.push_back(rdy);
            end
            p_req    = imem_req;
            p_gnt    = imem_gnt;
            p_addr   = imem_addr;
            p_kill   = ex | (bpe & ~stall);
            p_target = ex ? ex_t : bpe_t;
            p_load   = ~stall | p_kill;
        end

        chk("progress", 32'(n_loads > 300), 32'd1);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req",  32'(imem_req), 32'd0);
        chk("midrst_pc",   fe2de_pc_ffout, RESET_PC);
        chk("midrst_ir",   fe2de_ir_ffout, 32'd0);
        chk("midrst_pred", 32'(fe2de_predict_bxxtaken_ffout), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
